// File: rtl/fsm3onehot_pkg.sv
// fsm3onehot_pkg: shared state encoding and step function for the one-hot "101" recognizer.
package fsm3onehot_pkg;

    localparam int A = 0;
    localparam int B = 1;
    localparam int C = 2;
    localparam int D = 3;
    localparam int ST_W = 4;
    localparam logic [ST_W-1:0] ST_RESET = 4'b0001;

    function automatic logic [ST_W-1:0] step(input logic [ST_W-1:0] s, input logic in);
        logic [ST_W-1:0] n;
        n[A] = (s[A] | s[C]) & ~in;
        n[B] = (s[A] | s[B] | s[D]) & in;
        n[C] = (s[B] | s[D]) & ~in;
        n[D] = s[C] & in;
        return n;
    endfunction

endpackage

// File: rtl/fsm3onehot_step.sv
// fsm3onehot_step: combinational next-state datapath shared by all channels.
module fsm3onehot_step
    import fsm3onehot_pkg::*;
(
    input  logic [ST_W-1:0] i_state,
    input  logic            i_in,
    output logic [ST_W-1:0] o_next
);

    assign o_next = step(i_state, i_in);

endmodule

// File: rtl/fsm3onehot_sched.sv
// fsm3onehot_sched: round-robin time-multiplexing of one "101" recognizer step over NCH serial channels.
module fsm3onehot_sched
    import fsm3onehot_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] bit_in,
    input  logic [NCH-1:0] clr,
    output logic [NCH-1:0] ack,
    output logic           match_valid,
    output logic [CW-1:0]  match_ch,
    output logic [15:0]    match_cnt
);

    logic [ST_W-1:0] r_st [NCH];
    logic [CW-1:0]   r_ptr;
    logic [CW-1:0]   w_g;
    logic [CW-1:0]   w_idx;
    logic [NCH-1:0]  w_elig;
    logic            w_any;
    logic [ST_W-1:0] w_cur;
    logic [ST_W-1:0] w_next;
    logic            w_in;

    // Search starts just after the last granted channel, so every requester is served within NCH cycles.
    always_comb begin
        w_elig = resetn ? req & ~clr : '0;
        w_g    = '0;
        w_any  = 1'b0;
        w_idx  = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_idx = CW'((int'(r_ptr) + k) % NCH);
            if (!w_any && w_elig[w_idx]) begin
                w_any = 1'b1;
                w_g   = w_idx;
            end
        end
        ack = w_any ? NCH'(1) << w_g : '0;
    end

    assign w_cur = r_st[w_g];
    assign w_in  = bit_in[w_g];

    fsm3onehot_step u_step (
        .i_state (w_cur),
        .i_in    (w_in),
        .o_next  (w_next)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) r_st[i] <= ST_RESET;
            r_ptr       <= CW'(NCH - 1);
            match_valid <= 1'b0;
            match_ch    <= '0;
            match_cnt   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) r_st[i] <= ST_RESET;
                else if (w_any && w_g == CW'(i)) r_st[i] <= w_next;
            end
            if (w_any) r_ptr <= w_g;
            match_valid <= w_any & w_next[D];
            if (w_any && w_next[D]) begin
                match_ch  <= w_g;
                match_cnt <= match_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fsm3onehot_sched.sv
// tb_fsm3onehot_sched: directed vector table plus hand-written sequences for the shared-recognizer scheduler.
module tb_fsm3onehot_sched;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  bit_in;
    logic [3:0]  clr;
    logic [3:0]  ack;
    logic        match_valid;
    logic [1:0]  match_ch;
    logic [15:0] match_cnt;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] clr;
        logic [3:0] bits;
        logic [3:0] ack;
    } vec_t;

    vec_t tbl [13];
    int   grants [4];

    fsm3onehot_sched #(.NCH(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .bit_in      (bit_in),
        .clr         (clr),
        .ack         (ack),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic b);
        req        = 4'b0001 << ch;
        bit_in     = '0;
        bit_in[ch] = b;
        #1;
        check("send_ack", 16'(ack), 16'(4'b0001 << ch));
        tick;
    endtask

    initial begin
        resetn = 1'b0;
        req    = 4'hF;
        bit_in = '0;
        clr    = '0;
        for (int i = 0; i < 8; i++) tbl[i] = '{4'hF, 4'h0, 4'h0, 4'b0001 << (i % 4)};
        tbl[8]  = '{4'b0000, 4'b0000, 4'h0, 4'b0000};
        tbl[9]  = '{4'b0110, 4'b0000, 4'h0, 4'b0010};
        tbl[10] = '{4'b0110, 4'b0000, 4'h0, 4'b0100};
        tbl[11] = '{4'b1001, 4'b1000, 4'h0, 4'b0001};
        tbl[12] = '{4'b1001, 4'b0000, 4'h0, 4'b1000};

        // reset held two cycles with all channels requesting
        #1;
        check("rst_ack0", 16'(ack), 16'h0);
        tick;
        check("rst_ack1", 16'(ack), 16'h0);
        check("rst_mv", 16'(match_valid), 16'h0);
        check("rst_cnt", match_cnt, 16'h0);
        tick;
        check("rst_ack2", 16'(ack), 16'h0);
        resetn = 1'b1;
        #1;
        check("rel_ack", 16'(ack), 16'h1);

        // single stream 1,0,1 on ch0
        send(0, 1'b1);
        check("s_mv1", 16'(match_valid), 16'h0);
        send(0, 1'b0);
        check("s_mv2", 16'(match_valid), 16'h0);
        send(0, 1'b1);
        check("s_mv3", 16'(match_valid), 16'h1);
        check("s_ch", 16'(match_ch), 16'h0);
        check("s_cnt", match_cnt, 16'h1);
        check("s_st0", 16'(dut.r_st[0]), 16'h8);
        req = '0;
        #1;
        tick;
        check("s_pulse_end", 16'(match_valid), 16'h0);

        // fresh reset so round-robin starts at ch0, then the vector table
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        check("rr_cnt", match_cnt, 16'h0);
        for (int i = 0; i < 13; i++) begin
            req    = tbl[i].req;
            clr    = tbl[i].clr;
            bit_in = tbl[i].bits;
            #1;
            check($sformatf("vec%0d_ack", i), 16'(ack), 16'(tbl[i].ack));
            if (i < 8) for (int c = 0; c < 4; c++) grants[c] += int'(ack[c]);
            tick;
            check($sformatf("vec%0d_mv", i), 16'(match_valid), 16'h0);
        end
        for (int c = 0; c < 4; c++) check($sformatf("grants_ch%0d", c), 16'(grants[c]), 16'd2);
        clr = '0;

        // overlapping 10101 on ch2
        send(2, 1'b1);
        check("o_mv1", 16'(match_valid), 16'h0);
        send(2, 1'b0);
        check("o_mv2", 16'(match_valid), 16'h0);
        send(2, 1'b1);
        check("o_mv3", 16'(match_valid), 16'h1);
        check("o_ch3", 16'(match_ch), 16'h2);
        send(2, 1'b0);
        check("o_mv4", 16'(match_valid), 16'h0);
        check("o_hold_ch", 16'(match_ch), 16'h2);
        send(2, 1'b1);
        check("o_mv5", 16'(match_valid), 16'h1);
        check("o_ch5", 16'(match_ch), 16'h2);
        check("o_cnt", match_cnt, 16'h2);

        // clear collides with a request on ch1 while ptr=0
        send(1, 1'b1);
        check("c_st1_b", 16'(dut.r_st[1]), 16'h2);
        send(0, 1'b0);
        req    = 4'b0011;
        clr    = 4'b0010;
        bit_in = '0;
        #1;
        check("c_ack", 16'(ack), 16'h1);
        tick;
        check("c_st1_a", 16'(dut.r_st[1]), 16'h1);
        clr = '0;
        req = 4'b0010;
        #1;
        check("c_ack_next", 16'(ack), 16'h2);
        tick;

        // back-to-back matches from ch0 then ch3 (both primed with 1,0)
        send(0, 1'b1);
        send(0, 1'b0);
        send(3, 1'b1);
        send(3, 1'b0);
        req    = 4'b1001;
        bit_in = 4'b1001;
        #1;
        check("bb_ack0", 16'(ack), 16'h1);
        tick;
        check("bb_mv0", 16'(match_valid), 16'h1);
        check("bb_ch0", 16'(match_ch), 16'h0);
        req = 4'b1000;
        #1;
        check("bb_ack3", 16'(ack), 16'h8);
        tick;
        check("bb_mv3", 16'(match_valid), 16'h1);
        check("bb_ch3", 16'(match_ch), 16'h3);
        check("bb_cnt", match_cnt, 16'h4);
        req = '0;
        #1;

        // mid-stream reset discards the partial 1,0 on ch0
        send(0, 1'b1);
        send(0, 1'b0);
        resetn = 1'b0;
        req    = 4'b0001;
        #1;
        check("m_rst_ack", 16'(ack), 16'h0);
        tick;
        resetn = 1'b1;
        send(0, 1'b1);
        check("m_mv", 16'(match_valid), 16'h0);
        check("m_st0", 16'(dut.r_st[0]), 16'h2);
        check("m_cnt", match_cnt, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
